// File: rtl/led_pwm_ramp_pkg.sv
// Shared types and helpers for the LED PWM ramp block: FSM states, duty width
// and the saturating one-step ramp toward a target duty.
package led_pwm_pkg;

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_HOLD = 2'd1,
        S_RAMP = 2'd2
    } state_t;

    localparam int PWM_W = 8;
    localparam logic [PWM_W-1:0] PHASE_MAX = 8'hFF;

    // One ramp step from cur toward tgt; lands exactly on tgt when within step.
    function automatic logic [PWM_W-1:0] ramp_next(
        input logic [PWM_W-1:0] cur,
        input logic [PWM_W-1:0] tgt,
        input logic [PWM_W-1:0] step
    );
        logic signed [PWM_W:0] diff_s;
        logic        [PWM_W:0] mag_s;
        diff_s = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        mag_s  = diff_s[PWM_W] ? -diff_s : diff_s;
        if (mag_s <= {1'b0, step}) begin
            ramp_next = tgt;
        end else if (diff_s[PWM_W]) begin
            ramp_next = cur - step;
        end else begin
            ramp_next = cur + step;
        end
    endfunction

endpackage

// File: rtl/led_pwm_ramp_tick_gen.sv
// Prescaler producing a one-clock phase tick every PRESCALE clocks; the
// synchronous clear parks it at zero whenever the PWM is not running.
module pwm_tick_gen #(
    parameter int PRESCALE = 50
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_r;

    // Prescale counter: 0..PRESCALE-1, wraps after the tick cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (clear) begin
            cnt_r <= {CW{1'b0}};
        end else if (cnt_r == LAST) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    assign tick = (cnt_r == LAST);

endmodule

// File: rtl/led_pwm_ramp.sv
// LED PWM with glitch-free fading: the PIO value is a target brightness and
// the applied duty ramps toward it, changing only on PWM period boundaries.
module led_pwm_ramp
    import led_pwm_pkg::*;
#(
    parameter int PRESCALE     = 50,
    parameter int RAMP_STEP    = 1,
    parameter int RAMP_PERIODS = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [PWM_W-1:0] duty_in,
    output logic             pwm_out,
    output logic [PWM_W-1:0] duty_cur,
    output logic             period_start,
    output logic             ramp_busy
);

    localparam int PC_W = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
    localparam logic [PC_W-1:0]  PC_TOP = PC_W'(RAMP_PERIODS - 1);
    localparam logic [PWM_W-1:0] STEP   = PWM_W'(RAMP_STEP);

    state_t           state_r, state_nxt_s;
    logic [PWM_W-1:0] phase_r;
    logic [PWM_W-1:0] duty_r, duty_nxt_s;
    logic [PWM_W-1:0] target_r, target_nxt_s;
    logic [PC_W-1:0]  pc_r, pc_nxt_s;
    logic             pwm_r, pwm_nxt_s;
    logic             busy_r, busy_nxt_s;
    logic             run_s, clear_s, tick_s, tick_run_s;
    logic             period_start_s, step_due_s;
    logic [PWM_W-1:0] stepped_s;

    assign run_s          = (state_r != S_OFF);
    assign clear_s        = ~enable | ~run_s;
    assign tick_run_s     = tick_s & run_s;
    assign period_start_s = tick_run_s & (phase_r == {PWM_W{1'b0}});
    assign step_due_s     = (pc_r == PC_TOP);
    // Steps toward the freshly sampled value so a mid-ramp retarget acts at once.
    assign stepped_s      = ramp_next(duty_r, duty_in, STEP);

    pwm_tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (clear_s),
        .tick   (tick_s)
    );

    // Phase counter: one count per tick, 256 ticks per PWM period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_r <= {PWM_W{1'b0}};
        end else if (clear_s) begin
            phase_r <= {PWM_W{1'b0}};
        end else if (tick_run_s) begin
            phase_r <= (phase_r == PHASE_MAX) ? {PWM_W{1'b0}} : phase_r + PWM_W'(1);
        end else begin
            phase_r <= phase_r;
        end
    end

    // State, duty, target, period counter and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= S_OFF;
            duty_r   <= {PWM_W{1'b0}};
            target_r <= {PWM_W{1'b0}};
            pc_r     <= {PC_W{1'b0}};
            pwm_r    <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            duty_r   <= duty_nxt_s;
            target_r <= target_nxt_s;
            pc_r     <= pc_nxt_s;
            pwm_r    <= pwm_nxt_s;
            busy_r   <= busy_nxt_s;
        end
    end

    // Next-state logic; disable wins from any state.
    always_comb begin
        state_nxt_s = state_r;
        if (!enable) begin
            state_nxt_s = S_OFF;
        end else begin
            case (state_r)
                S_OFF: begin
                    state_nxt_s = S_HOLD;
                end
                S_HOLD: begin
                    if (period_start_s && (duty_in != duty_r)) begin
                        state_nxt_s = S_RAMP;
                    end else begin
                        state_nxt_s = S_HOLD;
                    end
                end
                S_RAMP: begin
                    if (period_start_s && (duty_nxt_s == duty_in)) begin
                        state_nxt_s = S_HOLD;
                    end else begin
                        state_nxt_s = S_RAMP;
                    end
                end
                default: begin
                    state_nxt_s = S_OFF;
                end
            endcase
        end
    end

    // Duty/target/period-counter updates, all confined to period_start.
    always_comb begin
        duty_nxt_s   = duty_r;
        target_nxt_s = target_r;
        pc_nxt_s     = pc_r;
        if (!enable || !run_s) begin
            duty_nxt_s = {PWM_W{1'b0}};
            pc_nxt_s   = {PC_W{1'b0}};
        end else if (period_start_s) begin
            target_nxt_s = duty_in;
            if (state_r == S_RAMP) begin
                if (step_due_s) begin
                    duty_nxt_s = stepped_s;
                    pc_nxt_s   = {PC_W{1'b0}};
                end else begin
                    pc_nxt_s = pc_r + PC_W'(1);
                end
            end else begin
                pc_nxt_s = {PC_W{1'b0}};
            end
        end else begin
            duty_nxt_s = duty_r;
        end
    end

    // Output decode ahead of the output registers.
    always_comb begin
        pwm_nxt_s  = enable & run_s & (phase_r < duty_r);
        busy_nxt_s = (state_nxt_s == S_RAMP);
    end

    assign pwm_out      = pwm_r;
    assign duty_cur     = duty_r;
    assign period_start = period_start_s;
    assign ramp_busy    = busy_r;

endmodule

// File: tb/tb_led_pwm_ramp.sv
// Bench for led_pwm_ramp: two instances (ramp step 1 and 100) checked every
// cycle against a time-based behavioural model plus directed literal checks.
module tb_led_pwm_ramp;

    localparam int P   = 2;
    localparam int PER = 256 * P;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable_a = 1'b0, enable_b = 1'b0;
    logic [7:0] duty_a = 8'd0, duty_b = 8'd0;
    logic       pwm_a, ps_a, busy_a, pwm_b, ps_b, busy_b;
    logic [7:0] cur_a, cur_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    led_pwm_ramp #(.PRESCALE(P), .RAMP_STEP(1), .RAMP_PERIODS(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .enable(enable_a), .duty_in(duty_a),
        .pwm_out(pwm_a), .duty_cur(cur_a), .period_start(ps_a), .ramp_busy(busy_a)
    );

    led_pwm_ramp #(.PRESCALE(P), .RAMP_STEP(100), .RAMP_PERIODS(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .enable(enable_b), .duty_in(duty_b),
        .pwm_out(pwm_b), .duty_cur(cur_b), .period_start(ps_b), .ramp_busy(busy_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: time since enable, duty, target, ramp flag per instance
    bit m_on   [2];
    int m_t    [2];
    int m_duty [2];
    int m_tgt  [2];
    bit m_ramp [2];
    bit m_pwm  [2];
    int m_step [2] = '{1, 100};

    function automatic int toward(input int cur, input int tgt, input int step);
        if (tgt > cur) return (cur + step > tgt) ? tgt : cur + step;
        else           return (cur - step < tgt) ? tgt : cur - step;
    endfunction

    task automatic model_reset(input int i);
        m_on[i] = 0; m_t[i] = 0; m_duty[i] = 0; m_tgt[i] = 0; m_ramp[i] = 0; m_pwm[i] = 0;
    endtask

    task automatic model_edge(input int i, input logic en, input logic [7:0] din);
        int  phase;
        bit  ps;
        if (!reset_n) begin
            model_reset(i);
        end else if (!en) begin
            m_on[i] = 0; m_t[i] = 0; m_duty[i] = 0; m_ramp[i] = 0; m_pwm[i] = 0;
        end else if (!m_on[i]) begin
            m_on[i] = 1; m_t[i] = 0; m_pwm[i] = 0;
        end else begin
            phase    = (m_t[i] / P) % 256;
            ps       = ((m_t[i] % PER) == P - 1);
            m_pwm[i] = (phase < m_duty[i]);
            if (ps) begin
                m_tgt[i] = din;
                if (m_ramp[i]) begin
                    m_duty[i] = toward(m_duty[i], m_tgt[i], m_step[i]);
                    if (m_duty[i] == m_tgt[i]) m_ramp[i] = 0;
                end else if (m_tgt[i] != m_duty[i]) begin
                    m_ramp[i] = 1;
                end
            end
            m_t[i]++;
        end
    endtask

    // Single compare process: model advances on posedge, outputs checked on negedge.
    initial begin
        forever begin
            @(posedge clk);
            model_edge(0, enable_a, duty_a);
            model_edge(1, enable_b, duty_b);
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!reset_n) model_reset(i);
                chk(i == 0 ? "cmp_pwm_a"  : "cmp_pwm_b",  i == 0 ? pwm_a  : pwm_b,  m_pwm[i]);
                chk(i == 0 ? "cmp_duty_a" : "cmp_duty_b", i == 0 ? cur_a  : cur_b,  m_duty[i]);
                chk(i == 0 ? "cmp_ps_a"   : "cmp_ps_b",   i == 0 ? ps_a   : ps_b,
                    m_on[i] && ((m_t[i] % PER) == P - 1));
                chk(i == 0 ? "cmp_busy_a" : "cmp_busy_b", i == 0 ? busy_a : busy_b, m_ramp[i]);
            end
        end
    end

    function automatic logic get_ps(input int i);
        return (i == 0) ? ps_a : ps_b;
    endfunction

    function automatic logic get_pwm(input int i);
        return (i == 0) ? pwm_a : pwm_b;
    endfunction

    // High-clock count over one period and spacing to the next period_start.
    task automatic measure(input int i, output int hi, output int sp);
        int k;
        hi = 0; sp = 0; k = 0;
        while (get_ps(i) !== 1'b1 && k < 2 * PER) begin
            @(negedge clk); k++;
        end
        chk("meas_ps_found", get_ps(i), 1);
        for (int j = 1; j <= PER; j++) begin
            @(negedge clk);
            if (get_pwm(i) === 1'b1) hi++;
            if (get_ps(i) === 1'b1 && sp == 0) sp = j;
        end
    endtask

    initial begin
        int k, hi, sp, exp_d, idx, seen;
        int up_list [3] = '{100, 200, 255};

        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;

        // 1: reset mid-run while pwm_out is high
        @(negedge clk); #1 enable_a = 1'b1; duty_a = 8'h40;
        k = 0;
        while (pwm_a !== 1'b1 && k < 3000) begin @(negedge clk); k++; end
        chk("t1_pwm_seen", pwm_a, 1);
        #1 reset_n = 1'b0; enable_a = 1'b0;
        #1;
        chk("t1_rst_pwm", pwm_a, 0);
        chk("t1_rst_duty", cur_a, 0);
        chk("t1_rst_ps", ps_a, 0);
        chk("t1_rst_busy", busy_a, 0);
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("t1_off_duty", cur_a, 0);
        chk("t1_off_ps", ps_a, 0);
        chk("t1_off_pwm", pwm_a, 0);

        // 5a: duty 0 steady -> never high, period 512 clk
        #1 enable_a = 1'b1; duty_a = 8'h00;
        measure(0, hi, sp);
        chk("t5_zero_high", hi, 0);
        chk("t5_zero_period", sp, 512);

        // 2: fade 0 -> 64 one step per period, then 128 high clocks per period
        #1 duty_a = 8'h40;
        exp_d = 1; k = 0;
        while (cur_a != 8'd64 && k < 70 * PER) begin
            @(negedge clk); k++;
            if (cur_a != 8'(exp_d - 1)) begin chk("t2_step", cur_a, exp_d); exp_d++; end
        end
        chk("t2_reach", cur_a, 64);
        chk("t2_busy_low", busy_a, 0);
        measure(0, hi, sp);
        chk("t2_high_clk", hi, 128);
        chk("t2_period", sp, 512);

        // 4: retarget mid-ramp reverses direction at the next boundary only
        #1 duty_a = 8'd200;
        exp_d = 65; k = 0;
        while (cur_a != 8'd70 && k < 10 * PER) begin
            @(negedge clk); k++;
            if (cur_a != 8'(exp_d - 1)) begin chk("t4_up_step", cur_a, exp_d); exp_d++; end
        end
        chk("t4_at70", cur_a, 70);
        repeat (100) @(negedge clk);
        #1 duty_a = 8'd50;
        k = 0;
        while (ps_a !== 1'b1 && k < 2 * PER) begin @(negedge clk); k++; end
        chk("t4_hold_midperiod", cur_a, 70);
        @(negedge clk);
        chk("t4_first_down", cur_a, 69);
        exp_d = 68; k = 0;
        while (cur_a != 8'd50 && k < 25 * PER) begin
            @(negedge clk); k++;
            if (cur_a != 8'(exp_d + 1)) begin chk("t4_down_step", cur_a, exp_d); exp_d--; end
        end
        chk("t4_reach", cur_a, 50);
        chk("t4_busy_low", busy_a, 0);

        // 6: drop enable mid-period, then re-enable fades in from 0
        k = 0;
        while (ps_a !== 1'b1 && k < 2 * PER) begin @(negedge clk); k++; end
        repeat (40) @(negedge clk);
        chk("t6_pwm_before", pwm_a, 1);
        #1 enable_a = 1'b0;
        @(negedge clk);
        chk("t6_off_pwm", pwm_a, 0);
        chk("t6_off_duty", cur_a, 0);
        chk("t6_off_busy", busy_a, 0);
        seen = 0;
        repeat (10) begin @(negedge clk); if (ps_a === 1'b1) seen++; end
        chk("t6_off_no_ps", seen, 0);
        #1 enable_a = 1'b1;
        k = 0;
        while (cur_a == 8'd0 && k < 3 * PER) begin @(negedge clk); k++; end
        chk("t6_refade_first", cur_a, 1);
        chk("t6_refade_busy", busy_a, 1);

        // 3: step 100 toward 255 saturates without wrap
        #1 enable_b = 1'b1; duty_b = 8'd255;
        idx = 0; k = 0; exp_d = 0;
        while (cur_b != 8'd255 && k < 8 * PER) begin
            @(negedge clk); k++;
            if (cur_b != 8'(exp_d)) begin
                chk("t3_step", cur_b, (idx < 3) ? up_list[idx] : 0);
                exp_d = cur_b;
                idx++;
            end
        end
        chk("t3_reach", cur_b, 255);
        chk("t3_nsteps", idx, 3);
        chk("t3_busy_low", busy_b, 0);

        // 5b: duty 255 steady -> low exactly one tick (2 clk) per period
        measure(1, hi, sp);
        chk("t5_full_high", hi, 510);
        chk("t5_full_period", sp, 512);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
